// File: rtl/ddr3_test_pkg.sv
// Shared types and helpers for the DDR3 Avalon pattern tester.
package ddr3_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CAL,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [15:0] ERR_SAT = 16'hFFFF;

  // Address-derived test word; callers replicate it across the data bus.
  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/ddr3_rd_checker.sv
// In-order read-return checker: tracks the return address, compares against the
// expected pattern and keeps a saturating error count plus the first failing address.
module ddr3_rd_checker
  import ddr3_test_pkg::*;
#(
  parameter int          ADDR_W = 24,
  parameter int          DATA_W = 64,
  parameter logic [31:0] SEED   = 32'hA5C3_1E0F
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  logic [ADDR_W-1:0] ret_addr_q;
  logic [ADDR_W-1:0] first_err_q;
  logic [15:0]       err_q;
  logic              mismatch;

  assign mismatch = valid_i && (rdata_i != {(DATA_W/32){pattern(32'(ret_addr_q), SEED)}});

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      ret_addr_q  <= '0;
      first_err_q <= '0;
      err_q       <= '0;
    end else if (valid_i) begin
      ret_addr_q <= ret_addr_q + ADDR_W'(1);
      if (mismatch) begin
        if (err_q != ERR_SAT) err_q <= err_q + 16'd1;
        // err_q never returns to zero once set, so it doubles as a "seen" flag.
        if (err_q == '0) first_err_q <= ret_addr_q;
      end
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: rtl/ddr3_avl_pattern_tester.sv
// Built-in DDR3 tester on the EMIF Avalon-MM port: write a pattern window,
// read it back with bounded outstanding reads, and report pass/fail stats.
module ddr3_avl_pattern_tester
  import ddr3_test_pkg::*;
#(
  parameter int          ADDR_W    = 24,
  parameter int          DATA_W    = 64,
  parameter int          NUM_WORDS = 1024,
  parameter logic [31:0] SEED      = 32'hA5C3_1E0F,
  parameter int          MAX_OUTST = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                local_init_done,
  input  logic                local_cal_success,
  input  logic                local_cal_fail,
  input  logic                avl_ready,
  output logic [ADDR_W-1:0]   avl_addr,
  output logic                avl_write_req,
  output logic                avl_read_req,
  output logic [DATA_W-1:0]   avl_wdata,
  output logic [DATA_W/8-1:0] avl_be,
  output logic [2:0]          avl_size,
  input  logic [DATA_W-1:0]   avl_rdata,
  input  logic                avl_rdata_valid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                cal_failed,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int                CW        = $clog2(MAX_OUTST + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CW-1:0]     MAX_CNT   = CW'(MAX_OUTST);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              pass_q, pass_d, cal_failed_q, cal_failed_d;
  logic              clear, wr_acc, rd_acc, ret_vld;

  assign wr_acc  = wr_q && avl_ready;
  assign rd_acc  = rd_q && avl_ready;
  // Returns with nothing outstanding are stray beats and must not move any counter.
  assign ret_vld = avl_rdata_valid && (outst_q != '0);
  assign outst_d = outst_q + CW'(rd_acc) - CW'(ret_vld);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    cal_failed_d = cal_failed_q;
    clear        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_WAIT_CAL;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          cal_failed_d = 1'b0;
          clear        = 1'b1;
        end
      end
      S_WAIT_CAL: begin
        if (local_cal_fail) begin
          state_d      = S_DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cal_failed_d = 1'b1;
        end else if (local_init_done && local_cal_success) begin
          state_d = S_WRITE;
          wr_d    = 1'b1;
          addr_d  = '0;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_READ;
            wr_d    = 1'b0;
            addr_d  = '0;
            rd_d    = (outst_d < MAX_CNT);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_READ: begin
        // A stalled request is held untouched; otherwise re-evaluate the throttle.
        if (rd_acc && (addr_q == LAST_ADDR)) begin
          state_d = S_DRAIN;
          rd_d    = 1'b0;
        end else if (rd_acc || !rd_q) begin
          if (rd_acc) addr_d = addr_q + ADDR_W'(1);
          rd_d = (outst_d < MAX_CNT);
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
    wdata_d = wr_d ? {(DATA_W/32){pattern(32'(addr_d), SEED)}} : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      wdata_q      <= '0;
      outst_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      cal_failed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      outst_q      <= outst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      cal_failed_q <= cal_failed_d;
    end
  end

  ddr3_rd_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_chk (
    .clk              (clk),
    .reset_n          (reset_n),
    .clear            (clear),
    .valid_i          (ret_vld),
    .rdata_i          (avl_rdata),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr)
  );

  assign avl_addr      = addr_q;
  assign avl_write_req = wr_q;
  assign avl_read_req  = rd_q;
  assign avl_wdata     = wdata_q;
  assign avl_be        = '1;
  assign avl_size      = 3'd1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign cal_failed    = cal_failed_q;

endmodule

// File: tb/tb_ddr3_avl_pattern_tester.sv
// Bench for ddr3_avl_pattern_tester: Avalon memory model with a read-latency
// queue, address/result scoreboards, and a second instance for saturation.
module tb_ddr3_avl_pattern_tester;

  localparam int          AW   = 24;
  localparam int          DW   = 64;
  localparam int          NW   = 16;
  localparam logic [31:0] SEED = 32'hA5C3_1E0F;

  typedef struct {logic [DW-1:0] d; int due;} rd_t;
  typedef struct {logic pass; logic calf; logic [15:0] ec; logic [AW-1:0] fa;} res_t;

  logic clk = 1'b0, fclk = 1'b0;
  logic reset_n = 1'b0, start = 1'b0;
  logic init_done = 1'b1, cal_ok = 1'b1, cal_fail = 1'b0;
  logic avl_ready = 1'b1, rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [AW-1:0] avl_addr, first_err_addr;
  logic wr_req, rd_req, busy, done, pass, cal_failed;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] be;
  logic [2:0] size;
  logic [15:0] err_count;

  logic s_reset_n = 1'b0, s_start = 1'b0, s_one = 1'b1, s_zero = 1'b0;
  logic s_rvalid = 1'b0, s_pend = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  logic [AW-1:0] s_addr, s_fa;
  logic s_wr, s_rd, s_busy, s_done, s_pass, s_calf;
  logic [DW-1:0] s_wdata;
  logic [DW/8-1:0] s_be;
  logic [2:0] s_size;
  logic [15:0] s_ec;
  bit sat_fin = 0;

  always #5 clk = ~clk;
  always #1 fclk = ~fclk;

  ddr3_avl_pattern_tester #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .SEED(SEED), .MAX_OUTST(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .local_init_done(init_done),
    .local_cal_success(cal_ok), .local_cal_fail(cal_fail), .avl_ready(avl_ready),
    .avl_addr(avl_addr), .avl_write_req(wr_req), .avl_read_req(rd_req), .avl_wdata(wdata),
    .avl_be(be), .avl_size(size), .avl_rdata(rdata), .avl_rdata_valid(rvalid),
    .busy(busy), .done(done), .pass(pass), .cal_failed(cal_failed),
    .err_count(err_count), .first_err_addr(first_err_addr));

  ddr3_avl_pattern_tester #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(70000), .SEED(SEED), .MAX_OUTST(8)) dut_sat (
    .clk(fclk), .reset_n(s_reset_n), .start(s_start), .local_init_done(s_one),
    .local_cal_success(s_one), .local_cal_fail(s_zero), .avl_ready(s_one),
    .avl_addr(s_addr), .avl_write_req(s_wr), .avl_read_req(s_rd), .avl_wdata(s_wdata),
    .avl_be(s_be), .avl_size(s_size), .avl_rdata(s_rdata), .avl_rdata_valid(s_rvalid),
    .busy(s_busy), .done(s_done), .pass(s_pass), .cal_failed(s_calf),
    .err_count(s_ec), .first_err_addr(s_fa));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {2{SEED ^ {8'h00, a}}};
  endfunction

  rd_t rq[$];
  res_t res_q[$], sres_q[$];
  res_t er, sr;
  logic [AW-1:0] wr_exp_q[$], rd_exp_q[$];
  logic [AW-1:0] ea;
  logic [DW-1:0] mem [NW];
  int cyc = 0, lat = 1, last_vld = -1, wr_first = -1, wr_last = -1, n_req = 0;
  bit rand_rdy = 0;
  logic [NW-1:0] corrupt = '0;
  logic p_stall = 1'b0, p_wr = 1'b0, p_rd = 1'b0, p_done = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;

  // Memory model and monitor; inputs change here, sampled at the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      rq.delete();
      rvalid = 1'b0; rdata = '0; avl_ready = 1'b1;
      p_stall = 1'b0; p_done = 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_wr", wr_req, p_wr);
        chk("hold_rd", rd_req, p_rd);
        chk("hold_addr", avl_addr, p_addr);
        chk("hold_wdata", wdata, p_wdata);
      end
      if (wr_req || rd_req) begin
        n_req++;
        chk("wr_rd_excl", wr_req & rd_req, 0);
      end
      if (done && !p_done) begin
        if (res_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          er = res_q.pop_front();
          chk("res_pass", pass, er.pass);
          chk("res_calf", cal_failed, er.calf);
          chk("res_errcnt", err_count, er.ec);
          chk("res_firstaddr", first_err_addr, er.fa);
          chk("res_busy", busy, 0);
          if (last_vld >= 0) chk("done_latency", cyc - last_vld, 2);
        end
      end
      p_done = done;
      avl_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rq.size() != 0 && rq[0].due <= cyc) begin
        rvalid = 1'b1; rdata = rq[0].d;
        void'(rq.pop_front());
        last_vld = cyc;
      end else begin
        rvalid = 1'b0; rdata = '0;
      end
      if (wr_req && avl_ready) begin
        if (wr_exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          ea = wr_exp_q.pop_front();
          chk("wr_addr", avl_addr, ea);
          chk("wr_data", wdata, pat(ea));
          if (ea == 5) chk("wr_data_a5", wdata, {2{32'hA5C3_1E0A}});
          mem[ea[3:0]] = wdata;
          if (wr_first < 0) wr_first = cyc;
          wr_last = cyc;
        end
      end
      if (rd_req && avl_ready) begin
        if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          ea = rd_exp_q.pop_front();
          chk("rd_addr", avl_addr, ea);
          rq.push_back('{mem[ea[3:0]] ^ DW'(corrupt[ea[3:0]]), cyc + lat});
          chk("outst_le8", rq.size() <= 8, 1);
        end
      end
      p_stall = (wr_req || rd_req) && !avl_ready;
      p_wr = wr_req; p_rd = rd_req; p_addr = avl_addr; p_wdata = wdata;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);           chk("rst_calf", cal_failed, 0);
    chk("rst_errcnt", err_count, 0);    chk("rst_firstaddr", first_err_addr, 0);
    chk("rst_wr", wr_req, 0);           chk("rst_rd", rd_req, 0);
    chk("rst_addr", avl_addr, 0);       chk("rst_wdata", wdata, 0);
    chk("rst_be", be, 8'hFF);           chk("rst_size", size, 3'd1);
  endtask

  task automatic push_window();
    for (int a = 0; a < NW; a++) begin
      wr_exp_q.push_back(AW'(a));
      rd_exp_q.push_back(AW'(a));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      seen = done;
    end
    chk(tag, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_test(input bit rr, input int l, input logic [NW-1:0] corr, input logic ep,
                          input logic [15:0] eec, input logic [AW-1:0] efa, input bit gate);
    rand_rdy = rr; lat = l; corrupt = corr;
    last_vld = -1; wr_first = -1; wr_last = -1;
    push_window();
    res_q.push_back('{ep, 1'b0, eec, efa});
    if (gate) begin init_done = 1'b0; cal_ok = 1'b0; end
    pulse_start();
    chk("busy_rise", busy, 1);
    if (gate) begin
      repeat (3) @(posedge clk);
      #1;
      chk("no_wr_before_cal", wr_req, 0);
      init_done = 1'b1; cal_ok = 1'b1;
      @(posedge clk); #1;
      chk("first_wr_timing", wr_req, 1);
    end
    wait_done("done_timeout");
    chk("wr_all_issued", wr_exp_q.size(), 0);
    chk("rd_all_issued", rd_exp_q.size(), 0);
    chk("result_consumed", res_q.size(), 0);
    if (!rr) chk("wr_back_to_back", wr_last - wr_first, NW - 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    reset_n = 1'b1;
    run_test(0, 1, '0, 1'b1, 16'd0, '0, 1);
    run_test(0, 1, 16'h0208, 1'b0, 16'd2, AW'(3), 0);
    run_test(1, 20, '0, 1'b1, 16'd0, '0, 0);

    init_done = 1'b0; cal_ok = 1'b0; cal_fail = 1'b1;
    n_req = 0; last_vld = -1;
    res_q.push_back('{1'b0, 1'b1, 16'd0, '0});
    pulse_start();
    wait_done("calf_timeout");
    chk("calf_done", done, 1);
    chk("calf_flag", cal_failed, 1);
    chk("calf_pass", pass, 0);
    chk("calf_no_req", n_req, 0);
    cal_fail = 1'b0; init_done = 1'b1; cal_ok = 1'b1;

    rand_rdy = 0; lat = 20; corrupt = '0;
    push_window();
    res_q.push_back('{1'b1, 1'b0, 16'd0, '0});
    pulse_start();
    for (int i = 0; i < 200 && rq.size() != 4; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_outst4", rq.size(), 4);
    chk("mid_reading", rd_req, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals();
    wr_exp_q.delete(); rd_exp_q.delete(); res_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_test(0, 1, '0, 1'b1, 16'd0, '0, 0);

    for (int i = 0; i < 40000 && !sat_fin; i++) @(posedge clk);
    chk("sat_finished", sat_fin, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Saturation instance: every read returns zero one cycle after acceptance.
  always @(negedge fclk) begin
    s_rvalid = s_pend;
    s_pend   = s_rd && s_reset_n;
  end

  initial begin
    bit seen = 0;
    repeat (3) @(negedge fclk);
    s_reset_n = 1'b1;
    sres_q.push_back('{1'b0, 1'b0, 16'hFFFF, '0});
    @(negedge fclk) s_start = 1'b1;
    @(negedge fclk) s_start = 1'b0;
    for (int i = 0; i < 200000 && !seen; i++) begin
      @(negedge fclk);
      seen = s_done;
    end
    chk("sat_done_timeout", seen, 1);
    if (seen) begin
      sr = sres_q.pop_front();
      chk("sat_errcnt", s_ec, sr.ec);
      chk("sat_firstaddr", s_fa, sr.fa);
      chk("sat_pass", s_pass, sr.pass);
      chk("sat_calf", s_calf, sr.calf);
    end
    sat_fin = 1;
  end

endmodule
